write_back_arbiter: RTL and testbench
=====================================

// Module: write_back_arbiter
// PURPOSE
//  Multi-source write-back stage for the GPR/FPR register files. Accepts results from
//  NUM_SRC execution units (ALU, load unit, FPU, ...) over valid/ready and buffers each
//  source in its own FIFO. Two independent round-robin arbiters issue at most one GPR
//  write and one FPR write per cycle. Sits between the execute/memory units and the
//  register files; replaces the single-result, single-cycle write-back.
// PARAMETERS
//  NUM_SRC     3   number of producing units (>=2)
//  QUEUE_DEPTH 4   entries per source FIFO (power of two, >=2)
//  REG_W       32  register data width
//  RADDR_W     5   register index width
// PORTS
//  clk        in   1                clock; all state on rising edge
//  rst        in   1                reset, asynchronous, active-high
//  src_valid  in   NUM_SRC          result valid, one bit per source
//  src_ready  out  NUM_SRC          source FIFO can accept
//  src_fpr    in   NUM_SRC          1 = FPR destination, 0 = GPR destination
//  src_rd     in   NUM_SRC*RADDR_W  destination index, source i at [i*RADDR_W +: RADDR_W]
//  src_data   in   NUM_SRC*REG_W    result data, source i at [i*REG_W +: REG_W]
//  gpr_we     out  1                GPR write enable (registered)
//  gpr_waddr  out  RADDR_W          GPR write index
//  gpr_wdata  out  REG_W            GPR write data
//  fpr_we     out  1                FPR write enable (registered)
//  fpr_waddr  out  RADDR_W          FPR write index
//  fpr_wdata  out  REG_W            FPR write data
//  wb_idle    out  1                all FIFOs empty and no write in flight
// BEHAVIOUR
//  - Reset (async): FIFOs empty, both RR pointers 0, all write outputs 0, src_ready 0
//    while rst is high, wb_idle 1. On the first edge after release, src_ready = all ones.
//  - Accept on src_valid[i] & src_ready[i]. src_ready[i] = (count_i != QUEUE_DEPTH),
//    computed from the registered count only; it does not depend on a same-cycle pop.
//    A full FIFO therefore never pushes and pops in the same cycle.
//    src_valid with src_ready low is ignored; the source holds its data.
//  - Only the FIFO head is a candidate. Candidate class = head.fpr. Each source pops at
//    most one entry per cycle; per-source order is preserved.
//  - GPR arbiter: grants the first GPR candidate at or after gptr, scanning modulo
//    NUM_SRC. On a grant, gptr <= winner+1, wrapping to 0. The FPR arbiter (fptr) is
//    identical and independent. Both may grant different sources in the same cycle.
//  - The grant registers the entry into the {g,f}pr_* outputs on the next edge and pops
//    it. we = 1 for exactly one cycle per entry.
//    GPR entry with rd==0: popped and counted, but gpr_we stays 0.
//  - With no grant, we = 0 and waddr/wdata hold their previous values.
//  - Latency (accept edge -> we high): 2 cycles; with bypass, see CONFIGURATION.
//    Throughput: 1 GPR + 1 FPR write per cycle sustained.
//  - Two sources targeting the same rd: written in grant order. No hazard check here.
//  - Pointer wrap: FIFO rd/wr pointers are log2(QUEUE_DEPTH) bits with an extra wrap bit.
//    full = equal index and different wrap bit.
//  - wb_idle = all counts 0 & !gpr_we & !fpr_we; used by the pipeline for drain/flush.
//  - Reset asserted mid-operation: buffered entries are discarded and no write is issued.
// CONFIGURATION
//  WB_BYPASS_EN defined: an accepted entry whose FIFO is empty joins arbitration in its
//    accept cycle. If granted, it skips the FIFO and writes on the next edge (latency 1).
//    If not granted, it is pushed normally.
//  WB_BYPASS_EN undefined: every entry passes through its FIFO (latency 2). Arbitration
//    then sees only registered heads, so there is no valid->we combinational path.
// STRUCTURE
//  - wb_pkg: typedef struct packed {logic fpr; logic [RADDR_W-1:0] rd;
//    logic [REG_W-1:0] data;} wb_entry_t; also the round-robin next-pointer function.
//  - Sub-module wb_fifo: one per source via generate; ports push/pop/head/count.
//  - Both arbiters and the output registers live in this module.
// TESTING
//  1 Reset: rst=1 mid-stream with 3 entries buffered -> we=0, wb_idle=1, src_ready=0.
//    After release: src_ready=3'b111 and no write from the stale entries.
//  2 Single: src0 GPR rd=5 data=32'hDEADBEEF -> gpr_we=1 for one cycle, waddr=5,
//    at accept+2 (accept+1 with WB_BYPASS_EN).
//  3 Round robin: all 3 sources push GPR every cycle -> grant order 0,1,2,0,...
//    One write per cycle; backpressure until each source has pushed QUEUE_DEPTH+1.
//  4 Dual class: src0 GPR rd=3 and src1 FPR rd=3 in the same cycle -> gpr_we and fpr_we
//    high in the same cycle with the correct data on each.
//  5 Full: hold src2 valid with the GPR path starved by sources 0/1.
//    src_ready[2]=0 after 4 pushes; no data lost; entries emerge in push order.
//  6 rd=0: src1 GPR rd=0 -> entry popped, gpr_we stays 0, wb_idle returns 1.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types for the write-back stage: the buffered result entry and the
// round-robin pointer advance used by both register-file arbiters.
package wb_pkg;

  localparam int WB_REG_W   = 32;
  localparam int WB_RADDR_W = 5;

  typedef struct packed {
    logic                  fpr;
    logic [WB_RADDR_W-1:0] rd;
    logic [WB_REG_W-1:0]   data;
  } wb_entry_t;

  // Pointer moves one past the winner so the winner has lowest priority next.
  function automatic int rr_next(input int winner, input int num);
    return (winner + 1 >= num) ? 0 : winner + 1;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Per-source result FIFO; pointers carry an extra wrap bit so that full and empty
// are told apart without a separate flag.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  wb_entry_t                push_entry,
  input  logic                     pop,
  output wb_entry_t                head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);

  wb_entry_t     mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;

  // NOTE: storage is not reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_entry;
  end

  // NOTE: registers use <= so every flop samples values from before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  assign head  = mem[rd_ptr[AW-1:0]];
  assign count = wr_ptr - rd_ptr;
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

endmodule

// File: rtl/write_back_arbiter.sv
// Multi-source write-back: per-source FIFOs feeding independent GPR and FPR
// round-robin arbiters. Optional WB_BYPASS_EN lets an entry skip an empty FIFO.
module write_back_arbiter
  import wb_pkg::*;
#(
  parameter int NUM_SRC     = 3,
  parameter int QUEUE_DEPTH = 4,
  parameter int REG_W       = WB_REG_W,
  parameter int RADDR_W     = WB_RADDR_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_SRC-1:0]         src_valid,
  output logic [NUM_SRC-1:0]         src_ready,
  input  logic [NUM_SRC-1:0]         src_fpr,
  input  logic [NUM_SRC*RADDR_W-1:0] src_rd,
  input  logic [NUM_SRC*REG_W-1:0]   src_data,
  output logic                       gpr_we,
  output logic [RADDR_W-1:0]         gpr_waddr,
  output logic [REG_W-1:0]           gpr_wdata,
  output logic                       fpr_we,
  output logic [RADDR_W-1:0]         fpr_waddr,
  output logic [REG_W-1:0]           fpr_wdata,
  output logic                       wb_idle
);

  localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

  wb_entry_t          in_entry   [NUM_SRC];
  wb_entry_t          head       [NUM_SRC];
  wb_entry_t          cand_entry [NUM_SRC];
  logic [CNT_W-1:0]   count      [NUM_SRC];
  logic [NUM_SRC-1:0] full, empty, accept, push, pop, cand_vld;
  logic [NUM_SRC-1:0] gpr_grant, fpr_grant;
  logic               ready_en;
  logic [PTR_W-1:0]   gptr, fptr, gpr_win, fpr_win;
  logic               gpr_any, fpr_any;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign in_entry[i] = '{fpr:  src_fpr[i],
                           rd:   src_rd[i*RADDR_W +: RADDR_W],
                           data: src_data[i*REG_W +: REG_W]};

    wb_fifo #(.DEPTH(QUEUE_DEPTH)) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (push[i]),
      .push_entry (in_entry[i]),
      .pop        (pop[i]),
      .head       (head[i]),
      .count      (count[i]),
      .full       (full[i])
    );

    assign empty[i]     = (count[i] == '0);
    // Ready comes from registered state only, so a full FIFO never push-pops.
    assign src_ready[i] = ready_en & ~full[i];
    assign accept[i]    = src_valid[i] & src_ready[i];

`ifdef WB_BYPASS_EN
    assign cand_vld[i]   = ~empty[i] | accept[i];
    assign cand_entry[i] = empty[i] ? in_entry[i] : head[i];
    assign push[i]       = accept[i] & ~(empty[i] & (gpr_grant[i] | fpr_grant[i]));
    assign pop[i]        = ~empty[i] & (gpr_grant[i] | fpr_grant[i]);
`else
    assign cand_vld[i]   = ~empty[i];
    assign cand_entry[i] = head[i];
    assign push[i]       = accept[i];
    assign pop[i]        = gpr_grant[i] | fpr_grant[i];
`endif
  end

  // NOTE: every output gets a default first so no path through here infers a latch.
  always_comb begin
    int gi, fi;
    gi        = 0;
    fi        = 0;
    gpr_grant = '0;
    fpr_grant = '0;
    gpr_any   = 1'b0;
    fpr_any   = 1'b0;
    gpr_win   = '0;
    fpr_win   = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      gi = (int'(gptr) + k) % NUM_SRC;
      fi = (int'(fptr) + k) % NUM_SRC;
      if (!gpr_any && cand_vld[gi] && !cand_entry[gi].fpr) begin
        gpr_any       = 1'b1;
        gpr_win       = PTR_W'(gi);
        gpr_grant[gi] = 1'b1;
      end
      if (!fpr_any && cand_vld[fi] && cand_entry[fi].fpr) begin
        fpr_any       = 1'b1;
        fpr_win       = PTR_W'(fi);
        fpr_grant[fi] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_en  <= 1'b0;
      gptr      <= '0;
      fptr      <= '0;
      gpr_we    <= 1'b0;
      gpr_waddr <= '0;
      gpr_wdata <= '0;
      fpr_we    <= 1'b0;
      fpr_waddr <= '0;
      fpr_wdata <= '0;
    end else begin
      ready_en <= 1'b1;
      gpr_we   <= 1'b0;
      fpr_we   <= 1'b0;
      if (gpr_any) begin
        gptr <= PTR_W'(rr_next(int'(gpr_win), NUM_SRC));
        // Writes to r0 are consumed silently; the address/data outputs hold.
        if (cand_entry[gpr_win].rd != '0) begin
          gpr_we    <= 1'b1;
          gpr_waddr <= cand_entry[gpr_win].rd;
          gpr_wdata <= cand_entry[gpr_win].data;
        end
      end
      if (fpr_any) begin
        fptr      <= PTR_W'(rr_next(int'(fpr_win), NUM_SRC));
        fpr_we    <= 1'b1;
        fpr_waddr <= cand_entry[fpr_win].rd;
        fpr_wdata <= cand_entry[fpr_win].data;
      end
    end
  end

  assign wb_idle = (&empty) & ~gpr_we & ~fpr_we;

endmodule

// File: tb/tb_write_back_arbiter.sv
// Directed scoreboard bench for write_back_arbiter; expectations follow WB_BYPASS_EN.
module tb_write_back_arbiter;
  import wb_pkg::*;

  localparam int NS = 3;
  localparam int AW = 5;
  localparam int RW = 32;
`ifdef WB_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NS-1:0]    src_valid = '0;
  logic [NS-1:0]    src_ready;
  logic [NS-1:0]    src_fpr = '0;
  logic [NS*AW-1:0] src_rd = '0;
  logic [NS*RW-1:0] src_data = '0;
  logic             gpr_we, fpr_we, wb_idle;
  logic [AW-1:0]    gpr_waddr, fpr_waddr;
  logic [RW-1:0]    gpr_wdata, fpr_wdata;

  int checks   = 0;
  int failures = 0;

  wb_entry_t     pend [NS][$];
  wb_entry_t     exp_g[$];
  wb_entry_t     exp_f[$];
  logic [NS-1:0] acc = '0;

  write_back_arbiter #(.NUM_SRC(NS), .QUEUE_DEPTH(4), .REG_W(RW), .RADDR_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .src_valid (src_valid),
    .src_ready (src_ready),
    .src_fpr   (src_fpr),
    .src_rd    (src_rd),
    .src_data  (src_data),
    .gpr_we    (gpr_we),
    .gpr_waddr (gpr_waddr),
    .gpr_wdata (gpr_wdata),
    .fpr_we    (fpr_we),
    .fpr_waddr (fpr_waddr),
    .fpr_wdata (fpr_wdata),
    .wb_idle   (wb_idle)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic wb_entry_t mk(input logic f, input logic [AW-1:0] rd, input logic [RW-1:0] d);
    wb_entry_t e;
    e.fpr  = f;
    e.rd   = rd;
    e.data = d;
    return e;
  endfunction

  // Source driver: presents each pending head, remembers whether it will be taken.
  always @(posedge clk) begin
    wb_entry_t tmp;
    #1;
    for (int s = 0; s < NS; s++) begin
      if (acc[s]) tmp = pend[s].pop_front();
      if (pend[s].size() != 0) begin
        src_valid[s]          = 1'b1;
        src_fpr[s]            = pend[s][0].fpr;
        src_rd[s*AW +: AW]    = pend[s][0].rd;
        src_data[s*RW +: RW]  = pend[s][0].data;
        acc[s]                = src_ready[s];
      end else begin
        src_valid[s] = 1'b0;
        acc[s]       = 1'b0;
      end
    end
  end

  // Write monitor: each write must match the next expected entry of its class.
  always @(negedge clk) begin
    wb_entry_t e;
    if (gpr_we) begin
      if (exp_g.size() == 0) check("gpr_unexpected_we", gpr_we, 0);
      else begin
        e = exp_g.pop_front();
        check("gpr_waddr", gpr_waddr, e.rd);
        check("gpr_wdata", gpr_wdata, e.data);
      end
    end
    if (fpr_we) begin
      if (exp_f.size() == 0) check("fpr_unexpected_we", fpr_we, 0);
      else begin
        e = exp_f.pop_front();
        check("fpr_waddr", fpr_waddr, e.rd);
        check("fpr_wdata", fpr_wdata, e.data);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #2;
  endtask

  task automatic wait_drain(input string tag, output bit saw_full);
    int n;
    bit busy;
    n        = 0;
    busy     = 1'b1;
    saw_full = 1'b0;
    do begin
      @(negedge clk);
      n++;
      if (src_valid[2] && !src_ready[2]) saw_full = 1'b1;
      busy = (exp_g.size() != 0) || (exp_f.size() != 0) || !wb_idle;
      for (int s = 0; s < NS; s++) if (pend[s].size() != 0) busy = 1'b1;
    end while (busy && n < 400);
    check(tag, busy, 0);
  endtask

  initial begin
    wb_entry_t e;
    bit        full_seen;
    int        n;
    int        wr_cnt;

    // Reset values, then a reset that lands on three buffered entries.
    repeat (2) @(negedge clk);
    check("rst_gpr_we", gpr_we, 0);
    check("rst_fpr_we", fpr_we, 0);
    check("rst_idle", wb_idle, 1);
    check("rst_ready", src_ready, 0);
    rst = 1'b0;
    @(posedge clk); #2;
    check("ready_after_release", src_ready, 3'b111);
    pend[0].push_back(mk(1'b0, 5'd1, 32'h5157_0001));
    pend[1].push_back(mk(1'b0, 5'd2, 32'h5157_0002));
    pend[2].push_back(mk(1'b1, 5'd3, 32'h5157_0003));
    @(posedge clk); #2;
    @(posedge clk); #2;
    check("buffered_not_idle", wb_idle, 0);
    rst = 1'b1;
    #1;
    check("midrst_gpr_we", gpr_we, 0);
    check("midrst_fpr_we", fpr_we, 0);
    check("midrst_idle", wb_idle, 1);
    check("midrst_ready", src_ready, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #2;
    check("ready_after_rerelease", src_ready, 3'b111);
    repeat (4) @(negedge clk);
    check("stale_idle", wb_idle, 1);

    // Round robin: three GPR streams, grants rotate 0,1,2 every cycle.
    for (int r = 0; r < 6; r++) begin
      for (int s = 0; s < NS; s++) begin
        e = mk(1'b0, AW'(s*6 + r + 1), {8'(s), 8'(r), 16'hA5A5});
        pend[s].push_back(e);
        exp_g.push_back(e);
      end
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!gpr_we && n < 50);
    check("rr_start", gpr_we, 1);
    wr_cnt = 0;
    for (int i = 0; i < 18; i++) begin
      if (gpr_we) wr_cnt++;
      @(negedge clk);
    end
    check("rr_back_to_back", wr_cnt, 18);
    wait_drain("rr_drain", full_seen);

    // Single GPR entry: one-cycle write pulse at the configured latency.
    @(negedge clk);
    e = mk(1'b0, 5'd5, 32'hDEADBEEF);
    pend[0].push_back(e);
    exp_g.push_back(e);
    for (int c = 0; c <= LAT + 1; c++) begin
      @(posedge clk); #2;
      check($sformatf("single_we_c%0d", c), gpr_we, (c == LAT));
      if (c == LAT) check("single_waddr", gpr_waddr, 5);
    end
    check("single_hold_waddr", gpr_waddr, 5);
    check("single_hold_wdata", gpr_wdata, 32'hDEADBEEF);
    wait_drain("single_drain", full_seen);

    // Dual class: GPR and FPR to the same index in the same cycle.
    @(negedge clk);
    e = mk(1'b0, 5'd3, 32'h1111_0003);
    pend[0].push_back(e);
    exp_g.push_back(e);
    e = mk(1'b1, 5'd3, 32'h2222_0003);
    pend[1].push_back(e);
    exp_f.push_back(e);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(gpr_we || fpr_we) && n < 20);
    check("dual_gpr_we", gpr_we, 1);
    check("dual_fpr_we", fpr_we, 1);
    wait_drain("dual_drain", full_seen);

    // rd = 0: consumed without a write, stage goes idle again.
    @(negedge clk);
    pend[1].push_back(mk(1'b0, 5'd0, 32'h0BAD_0000));
    @(posedge clk); #2;
    @(posedge clk); #2;
    check("rd0_busy", wb_idle, (LAT == 1));
    @(posedge clk); #2;
    check("rd0_no_we", gpr_we, 0);
    check("rd0_idle", wb_idle, 1);
    wait_drain("rd0_drain", full_seen);

    // Full FIFO on source 2 under GPR contention; nothing lost, order kept.
    do_reset();
    for (int r = 0; r < 8; r++) begin
      for (int s = 0; s < NS; s++) begin
        e = mk(1'b0, AW'(s*8 + r + 1), {8'(s), 8'(r), 16'h5A5A});
        pend[s].push_back(e);
        exp_g.push_back(e);
      end
    end
    wait_drain("full_drain", full_seen);
    check("full_backpressure_seen", full_seen, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
